// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int RCA_DEFAULT_WIDTH = 9;

endpackage : rca_pkg

// File: rtl/rca_full_adder.sv
// One-bit full adder cell: the unit element of the ripple chain.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // The propagate term is shared by the sum and the carry-out.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : rca_full_adder

// File: rtl/rca_adder.sv
// Unsigned ripple-carry adder with a single registered output.
// The carry walks bit by bit through a chain of full-adder cells. The chain
// exists so it can serve as the reference ripple structure in timing and
// area comparisons. The result is exact in width+1 bits, and its MSB is the
// carry-out.
module rca_adder
    import rca_pkg::*;
#(
    parameter int width = RCA_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width:0]   sum_o
);

    logic [width:0]   carry;
    logic [width-1:0] s_p0;
    logic [width:0]   sum_p1;

    // Stage p0: combinational ripple chain, with the carry into bit 0 tied low.
    assign carry[0] = 1'b0;

    for (genvar k = 0; k < width; k++) begin : g_cell
        rca_full_adder u_fa (
            .a    (a_i[k]),
            .b    (b_i[k]),
            .cin  (carry[k]),
            .s    (s_p0[k]),
            .cout (carry[k+1])
        );
    end

    // Stage p1: capture the full-precision sum; reset clears it without a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_p1 <= '0;
        end else begin
            sum_p1 <= {carry[width], s_p0};
        end
    end

    assign sum_o = sum_p1;

endmodule : rca_adder

// File: tb/tb_rca_adder.sv
// Testbench for rca_adder. Three instances (width 9, 1 and 16) run in
// lockstep on shared operands, and each instance takes the low bits of
// those operands. Each driven operand pair pushes its expected sums onto
// a scoreboard queue. The queue entry is popped and compared one clock
// edge later.
module tb_rca_adder;

    logic        clk;
    logic        rst_n;
    logic [8:0]  a9,  b9;
    logic [9:0]  sum9;
    logic [0:0]  a1,  b1;
    logic [1:0]  sum1;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  e9;
        logic [1:0]  e1;
        logic [16:0] e16;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned e9;
        int unsigned e1;
        int unsigned e16;
    } vec_t;

    rca_adder #(.width(9)) dut9 (
        .clk_i (clk), .rst_ni (rst_n), .a_i (a9), .b_i (b9), .sum_o (sum9)
    );

    rca_adder #(.width(1)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .a_i (a1), .b_i (b1), .sum_o (sum1)
    );

    rca_adder #(.width(16)) dut16 (
        .clk_i (clk), .rst_ni (rst_n), .a_i (a16), .b_i (b16), .sum_o (sum16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_exp(input int unsigned a, input int unsigned b,
                             input int unsigned e9, input int unsigned e1, input int unsigned e16);
        exp_t e;
        a9  = a[8:0];
        b9  = b[8:0];
        a1  = a[0:0];
        b1  = b[0:0];
        a16 = a[15:0];
        b16 = b[15:0];
        e.e9  = e9[9:0];
        e.e1  = e1[1:0];
        e.e16 = e16[16:0];
        exp_q.push_back(e);
    endtask

    // Reference model: plain integer addition, truncated to each instance's operand width.
    task automatic drive(input int unsigned a, input int unsigned b);
        int unsigned m9, m1, m16;
        m9  = (a & 32'h1FF)  + (b & 32'h1FF);
        m1  = (a & 32'h1)    + (b & 32'h1);
        m16 = (a & 32'hFFFF) + (b & 32'hFFFF);
        drive_exp(a, b, m9, m1, m16);
    endtask

    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({name, " w9"},  sum9,  e.e9);
            chk({name, " w1"},  sum1,  e.e1);
            chk({name, " w16"}, sum16, e.e16);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " w9"},  sum9,  0);
        chk({name, " w1"},  sum1,  0);
        chk({name, " w16"}, sum16, 0);
    endtask

    initial begin
        vec_t vecs[$];
        int unsigned bs[5];

        vecs.push_back('{0,     0,     0,    0, 0});
        vecs.push_back('{3,     4,     7,    1, 7});
        vecs.push_back('{1,     1,     2,    2, 2});
        vecs.push_back('{100,   200,   300,  0, 300});
        vecs.push_back('{511,   1,     512,  2, 512});
        vecs.push_back('{511,   511,   1022, 2, 1022});
        vecs.push_back('{512,   512,   0,    0, 1024});
        vecs.push_back('{65535, 1,     512,  2, 65536});
        vecs.push_back('{65535, 65535, 1022, 2, 131070});
        vecs.push_back('{32768, 32768, 0,    0, 65536});
        vecs.push_back('{341,   170,   511,  1, 511});
        vecs.push_back('{255,   256,   511,  1, 511});
        vecs.push_back('{43690, 21845, 511,  1, 65535});
        vecs.push_back('{1,     0,     1,    1, 1});
        vecs.push_back('{0,     1,     1,    1, 1});

        // Reset held with non-zero operands: the outputs stay 0 before and across an edge.
        rst_n = 1'b0;
        a9 = 9'd77; b9 = 9'd99; a1 = 1'b1; b1 = 1'b1; a16 = 16'd1234; b16 = 16'd4321;
        #1;
        chk_zero("reset before edge");
        @(posedge clk);
        #1;
        chk_zero("reset after edge");

        // Release reset: the first capture happens on the next rising edge.
        rst_n = 1'b1;
        drive(3, 4);
        #2;
        chk_zero("release before edge");
        tick("release 3+4");

        // Table-driven vectors.
        foreach (vecs[i]) begin
            drive_exp(vecs[i].a, vecs[i].b, vecs[i].e9, vecs[i].e1, vecs[i].e16);
            tick($sformatf("vec%0d", i));
        end

        // Latency: back-to-back pairs, and the output holds until the following edge.
        drive(100, 200);
        tick("latency 100+200");
        drive(1, 1);
        #3;
        chk("latency hold w9", sum9, 300);
        tick("latency 1+1");

        // Full carry ripple sequence.
        drive(511, 1);
        tick("ripple 511+1");
        drive(511, 511);
        tick("ripple 511+511");

        // Asynchronous reset mid-stream, between edges, while the output reads 300.
        drive(100, 200);
        tick("pre-reset 100+200");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        a9 = 9'd5; b9 = 9'd6;
        @(posedge clk);
        #1;
        chk_zero("reset held across edge");
        rst_n = 1'b1;
        drive(5, 6);
        tick("resume 5+6");

        // Broad sweep: every a against a set of b values, b sweep at a=511, then random pairs.
        bs = '{0, 1, 170, 341, 511};
        for (int a = 0; a < 512; a++) begin
            for (int j = 0; j < 5; j++) begin
                drive(a, bs[j]);
                tick("sweep a");
            end
        end
        for (int b = 0; b < 512; b++) begin
            drive(511, b);
            tick("sweep b");
        end
        for (int n = 0; n < 6000; n++) begin
            drive($urandom_range(65535, 0), $urandom_range(65535, 0));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rca_adder

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Parameterised unsigned ripple-carry adder: a chain of 1-bit full adders computes a_i + b_i, including the carry-out.
- The full-precision result is registered once, giving a clean registered datapath output with a fixed 1-cycle latency.
- Used as a leaf arithmetic block and as the reference ripple structure for adder timing and area comparisons.

Parameters:
- width, 9, operand width in bits; legal range 1..64.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- a_i  input  width  operand A, unsigned.
- b_i  input  width  operand B, unsigned.
- sum_o  output  width+1  registered sum; bit [width] is the carry-out.

Behaviour:
- Arithmetic: sum_o = zero-extended a_i + zero-extended b_i, exact in width+1 bits. There is no overflow and no wrap.
- Carry-in of bit 0 is constant 0.
- Structure: width full-adder cells in series. Carry c[0] = 0. For each bit k: s[k] = a[k]^b[k]^c[k], and c[k+1] = a[k]&b[k] | c[k]&(a[k]^b[k]). The final carry c[width] forms sum bit [width].
- No carry-lookahead, prefix or behavioural "+" operator is allowed in the datapath; the ripple chain must be explicit.
- Register: the combinational result {c[width], s[width-1:0]} is captured into sum_o on each rising edge of clk_i.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on sum_o after edge N and hold until edge N+1.
- Throughput: one new operand pair per cycle. There is no handshake and no stall.
- Reset: while rst_ni = 0, sum_o = 0 immediately, independent of the clock.
- On rst_ni release, the first capture occurs at the next rising edge.
- If reset is asserted mid-stream, the in-flight result is discarded.
- Boundaries:
  - 0+0 gives 0.
  - max+max gives 2^(width+1)-2, with the carry-out set.
  - max+1 gives exactly 2^width: only bit [width] is set and all lower bits are 0.
- Timing target: the full ripple path from inputs to the sum_o register must close within one clock period. The block is not pipelined internally.
- Inputs that are X or Z are not specified. The bench drives only known values.

Decomposition:
- Shared package rca_pkg holds the constant RCA_DEFAULT_WIDTH = 9. The package needs no typedefs.
- One sub-module, rca_full_adder (inputs a, b, cin; outputs s, cout), is instantiated width times via a generate loop.
- The top module holds the carry vector and the output register only.

Test Plan:
- Reset: hold rst_ni = 0 with non-zero inputs → sum_o = 0 throughout, with no clock edges required. Release reset with a=3, b=4 → sum_o = 7 after the first edge.
- Latency: apply a=100, b=200 at edge N, then a=1, b=1 at edge N+1 → sum_o = 300 after edge N and 2 after edge N+1.
- Full carry ripple (width=9): a=511, b=1 → sum_o = 512 (10'b10_0000_0000). Then a=511, b=511 → sum_o = 1022.
- Exhaustive (width=9): all 512×512 pairs, one per cycle → every sum_o equals the a+b applied one cycle earlier, 10-bit compare, zero mismatches.
- Asynchronous reset mid-stream: assert rst_ni low between edges while sum_o = 300 → sum_o goes to 0 immediately. Deassert → normal operation resumes at the next edge.
- Width sweep: width = 1 (a=1, b=1 → 2) and width = 16 (a=65535, b=65535 → 131070) → correct results and carry-out.
